// File: rtl/useq_stacked.sv
// ---------------------------------------------------------------------------
// useq_stacked -- stacked microprogram sequencer (2910-style)
//
// Produces the next microaddress Y from a 4-bit opcode, a condition input,
// the direct data input D, the loop counter R and a return-address stack.
// The microprogram counter uPC always loads Y + CI on a non-held edge.
//
// Ports
//   clk        rising-edge clock
//   RST_BAR    asynchronous active-low reset
//   I          opcode (0..15)
//   CCEN_BAR   condition enable, low = test CC_BAR
//   CC_BAR     condition, low = pass
//   RLD_BAR    low forces R <- D
//   CI         carry into uPC increment
//   HOLD       freezes all state
//   ERR_CLR    clears sticky OVF/UNF
//   D          direct / branch data
//   Y          next microaddress (combinational)
//   SP         stack occupancy
//   FULL_BAR   low when the stack is full
//   EMPTY      high when the stack is empty
//   RZERO      high when R == 0
//   PL_BAR / MAP_BAR / VECT_BAR   source-select strobes, active low
//   OVF / UNF  sticky push-overflow / pop-underflow flags
// ---------------------------------------------------------------------------
module useq_stacked #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 5,
   localparam int SPW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             RST_BAR,
   input  logic [3:0]       I,
   input  logic             CCEN_BAR,
   input  logic             CC_BAR,
   input  logic             RLD_BAR,
   input  logic             CI,
   input  logic             HOLD,
   input  logic             ERR_CLR,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Y,
   output logic [SPW-1:0]   SP,
   output logic             FULL_BAR,
   output logic             EMPTY,
   output logic             RZERO,
   output logic             PL_BAR,
   output logic             MAP_BAR,
   output logic             VECT_BAR,
   output logic             OVF,
   output logic             UNF
);

   logic [WIDTH-1:0] uPC_q, uPC_d;
   logic [WIDTH-1:0] r_q;
   logic [SPW-1:0]   sp_q;
   logic             ovf_q, unf_q;
   logic [WIDTH-1:0] stack_q [DEPTH];

   logic             fail, rNonZero, spFull, spEmpty;
   logic [SPW-1:0]   tosIdx;
   logic [WIDTH-1:0] tos;
   logic             push, pop, clrSp, rLoad, rDec;

   assign fail     = CC_BAR & ~CCEN_BAR;
   assign rNonZero = (r_q != '0);
   assign spFull   = (sp_q == SPW'(DEPTH));
   assign spEmpty  = (sp_q == '0);
   assign tosIdx   = sp_q - SPW'(1);
   // Only live entries may reach Y; an empty stack reads as zero.
   assign tos      = spEmpty ? '0 : stack_q[tosIdx];

   assign SP       = sp_q;
   assign FULL_BAR = ~spFull;
   assign EMPTY    = spEmpty;
   assign RZERO    = ~rNonZero;
   assign OVF      = ovf_q;
   assign UNF      = unf_q;
   assign MAP_BAR  = ~(I == 4'd2);
   assign VECT_BAR = ~(I == 4'd6);
   assign PL_BAR   = ~MAP_BAR | ~VECT_BAR;

   // Opcode decode: next address plus the stack and counter actions.
   // Every decrement sits in an R != 0 branch, so R never wraps.
   always_comb begin
      Y     = uPC_q;
      push  = 1'b0;
      pop   = 1'b0;
      clrSp = 1'b0;
      rLoad = 1'b0;
      rDec  = 1'b0;
      case (I)
         4'd0:  begin Y = '0; clrSp = 1'b1; end
         4'd1:  if (!fail) begin Y = D; push = 1'b1; end
         4'd2:  Y = D;
         4'd3:  if (!fail) Y = D;
         4'd4:  begin push = 1'b1; rLoad = ~fail; end
         4'd5:  begin push = 1'b1; Y = fail ? r_q : D; end
         4'd6:  if (!fail) Y = D;
         4'd7:  Y = fail ? r_q : D;
         4'd8:  if (rNonZero) begin Y = tos; rDec = 1'b1; end
                else pop = 1'b1;
         4'd9:  if (rNonZero) begin Y = D; rDec = 1'b1; end
         4'd10: if (!fail) begin Y = tos; pop = 1'b1; end
         4'd11: if (!fail) begin Y = D; pop = 1'b1; end
         4'd12: rLoad = 1'b1;
         4'd13: if (fail) Y = tos;
                else pop = 1'b1;
         4'd14: Y = uPC_q;
         4'd15: begin
            if (rNonZero) begin
               rDec = 1'b1;
               if (fail) Y = tos;
               else pop = 1'b1;
            end else begin
               pop = 1'b1;
               if (fail) Y = D;
            end
         end
         default: Y = uPC_q;
      endcase
   end

   assign uPC_d = Y + WIDTH'(CI);

   // Architectural state. HOLD freezes everything except the error-clear,
   // and a fresh error on the same edge takes priority over the clear.
   always_ff @(posedge clk or negedge RST_BAR) begin
      if (!RST_BAR) begin
         uPC_q <= '0;
         r_q   <= '0;
         sp_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (!HOLD) begin
            uPC_q <= uPC_d;
            if (!RLD_BAR || rLoad)
               r_q <= D;
            else if (rDec)
               r_q <= r_q - WIDTH'(1);
            if (clrSp)
               sp_q <= '0;
            else if (push && !spFull)
               sp_q <= sp_q + SPW'(1);
            else if (pop && !spEmpty)
               sp_q <= sp_q - SPW'(1);
         end
         if (!HOLD && push && spFull)
            ovf_q <= 1'b1;
         else if (ERR_CLR)
            ovf_q <= 1'b0;
         if (!HOLD && pop && spEmpty)
            unf_q <= 1'b1;
         else if (ERR_CLR)
            unf_q <= 1'b0;
      end
   end

   // Stack storage carries no reset; a push saves the pre-edge uPC.
   always_ff @(posedge clk) begin
      if (RST_BAR && !HOLD && push && !spFull)
         stack_q[sp_q] <= uPC_q;
   end

endmodule

// File: tb/tb_useq_stacked.sv
// ---------------------------------------------------------------------------
// tb_useq_stacked -- directed self-checking bench for useq_stacked
// (default WIDTH = 12, DEPTH = 5). Inputs change one time unit after a
// rising edge; combinational Y is checked before the next edge and state
// outputs one time unit after it.
// ---------------------------------------------------------------------------
module tb_useq_stacked;

   localparam int WIDTH = 12;
   localparam int SPW   = 3;

   logic             clk;
   logic             RST_BAR;
   logic [3:0]       I;
   logic             CCEN_BAR, CC_BAR, RLD_BAR, CI, HOLD, ERR_CLR;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Y;
   logic [SPW-1:0]   SP;
   logic             FULL_BAR, EMPTY, RZERO, PL_BAR, MAP_BAR, VECT_BAR, OVF, UNF;

   int checkCount = 0;
   int passCount  = 0;

   useq_stacked dut (
      .clk(clk), .RST_BAR(RST_BAR), .I(I), .CCEN_BAR(CCEN_BAR), .CC_BAR(CC_BAR),
      .RLD_BAR(RLD_BAR), .CI(CI), .HOLD(HOLD), .ERR_CLR(ERR_CLR), .D(D),
      .Y(Y), .SP(SP), .FULL_BAR(FULL_BAR), .EMPTY(EMPTY), .RZERO(RZERO),
      .PL_BAR(PL_BAR), .MAP_BAR(MAP_BAR), .VECT_BAR(VECT_BAR), .OVF(OVF), .UNF(UNF)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: count it, credit it or report it.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checkCount++;
      if (actual === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
   endtask

   // Drive one instruction; isFail selects a failing tested condition,
   // otherwise the condition is disabled and therefore passes.
   task automatic applyStimulus(input logic [3:0] op, input logic isFail,
                                input logic [WIDTH-1:0] data);
      I        = op;
      CCEN_BAR = ~isFail;
      CC_BAR   = 1'b1;
      D        = data;
      #1;
   endtask

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   initial begin
      RST_BAR = 1'b0; I = 4'd14; CCEN_BAR = 1'b1; CC_BAR = 1'b1; RLD_BAR = 1'b1;
      CI = 1'b1; HOLD = 1'b0; ERR_CLR = 1'b0; D = '0;

      // Reset state
      #12;
      checkOutput("rst_sp", SP, 0);
      checkOutput("rst_empty", EMPTY, 1);
      checkOutput("rst_fullb", FULL_BAR, 1);
      checkOutput("rst_rzero", RZERO, 1);
      checkOutput("rst_ovf_unf", {OVF, UNF}, 0);
      checkOutput("rst_y", Y, 0);
      RST_BAR = 1'b1;

      // CONT with CI=1 walks 0,1,2,3 -> uPC=4
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("cont_y%0d", k), Y, k);
         stepClk();
      end
      checkOutput("cont_upc4", Y, 4);
      checkOutput("cont_sp", SP, 0);

      // JMAP to 0x010 (uPC becomes 0x011), CJS 0x100 pushes 0x011, CRTN returns
      applyStimulus(4'd2, 1'b0, 12'h010);
      checkOutput("jmap_strobes", {PL_BAR, MAP_BAR, VECT_BAR}, 3'b101);
      checkOutput("jmap_y", Y, 12'h010);
      stepClk();
      applyStimulus(4'd1, 1'b1, 12'h100);
      checkOutput("cjs_fail_y", Y, 12'h011);
      applyStimulus(4'd1, 1'b0, 12'h100);
      checkOutput("cjs_pass_y", Y, 12'h100);
      stepClk();
      checkOutput("cjs_sp", SP, 1);
      applyStimulus(4'd10, 1'b0, 12'h000);
      checkOutput("crtn_y", Y, 12'h011);
      stepClk();
      checkOutput("crtn_sp", SP, 0);
      checkOutput("crtn_empty", EMPTY, 1);

      // Underflow: CRTN on empty stack (uPC=0x012)
      applyStimulus(4'd10, 1'b0, 12'h000);
      checkOutput("unf_y", Y, 0);
      stepClk();
      checkOutput("unf_flag", UNF, 1);
      checkOutput("unf_sp", SP, 0);
      applyStimulus(4'd14, 1'b0, 12'h000);
      ERR_CLR = 1'b1;
      stepClk();
      ERR_CLR = 1'b0;
      checkOutput("unf_clr", UNF, 0);

      // Six failing PUSHes from uPC=2: stack 2..6, sixth overflows
      for (int k = 0; k < 6; k++) begin
         applyStimulus(4'd4, 1'b1, 12'h000);
         checkOutput($sformatf("push_y%0d", k), Y, 2 + k);
         stepClk();
         if (k == 4) begin
            checkOutput("push5_sp", SP, 5);
            checkOutput("push5_fullb", FULL_BAR, 0);
            checkOutput("push5_ovf", OVF, 0);
         end
      end
      checkOutput("ovf_flag", OVF, 1);
      checkOutput("ovf_sp", SP, 5);
      applyStimulus(4'd13, 1'b1, 12'h000);
      checkOutput("ovf_tos_kept", Y, 6);
      // Error on the same edge as ERR_CLR keeps the flag set
      applyStimulus(4'd4, 1'b1, 12'h000);
      ERR_CLR = 1'b1;
      stepClk();
      checkOutput("ovf_wins_clr", OVF, 1);
      applyStimulus(4'd14, 1'b0, 12'h000);
      stepClk();
      ERR_CLR = 1'b0;
      checkOutput("ovf_clr", OVF, 0);

      // JZ clears the stack without touching flags (uPC was 10)
      applyStimulus(4'd0, 1'b0, 12'h000);
      checkOutput("jz_y", Y, 0);
      stepClk();
      checkOutput("jz_sp", SP, 0);
      checkOutput("jz_flags", {OVF, UNF}, 0);

      // LDCT R=3, push A=2, RFCT loops to A three times then falls through
      applyStimulus(4'd12, 1'b0, 12'd3);
      checkOutput("ldct_y", Y, 1);
      stepClk();
      checkOutput("ldct_rzero", RZERO, 0);
      applyStimulus(4'd4, 1'b1, 12'h000);
      stepClk();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(4'd8, 1'b0, 12'h000);
         checkOutput($sformatf("rfct_loop%0d", k), Y, 2);
         stepClk();
      end
      checkOutput("rfct_rzero", RZERO, 1);
      applyStimulus(4'd8, 1'b0, 12'h000);
      checkOutput("rfct_exit_y", Y, 3);
      stepClk();
      checkOutput("rfct_exit_sp", SP, 0);

      // Push 4 (SP=1), LDCT R=2 (uPC=6), then hold RPCT for three edges
      applyStimulus(4'd4, 1'b1, 12'h000);
      stepClk();
      applyStimulus(4'd12, 1'b0, 12'd2);
      stepClk();
      HOLD = 1'b1;
      applyStimulus(4'd9, 1'b0, 12'h0AB);
      checkOutput("rpct_hold_y", Y, 12'h0AB);
      for (int k = 0; k < 3; k++) stepClk();
      checkOutput("hold_rzero", RZERO, 0);
      checkOutput("hold_sp", SP, 1);
      checkOutput("hold_y", Y, 12'h0AB);
      applyStimulus(4'd14, 1'b0, 12'h000);
      checkOutput("hold_upc", Y, 6);
      // Asynchronous reset while held
      RST_BAR = 1'b0;
      #2;
      checkOutput("arst_sp", SP, 0);
      checkOutput("arst_y", Y, 0);
      checkOutput("arst_rzero", RZERO, 1);
      RST_BAR = 1'b1;
      HOLD = 1'b0;
      stepClk();
      checkOutput("post_rst_y", Y, 1);

      // JRP fail takes R, CJV pass vectors, CJP fail continues, RLD_BAR loads R
      applyStimulus(4'd12, 1'b0, 12'h055);
      stepClk();
      applyStimulus(4'd7, 1'b1, 12'h300);
      checkOutput("jrp_fail_y", Y, 12'h055);
      stepClk();
      applyStimulus(4'd6, 1'b0, 12'h300);
      checkOutput("cjv_strobes", {PL_BAR, MAP_BAR, VECT_BAR}, 3'b110);
      checkOutput("cjv_y", Y, 12'h300);
      applyStimulus(4'd3, 1'b1, 12'h300);
      checkOutput("cjp_fail_y", Y, 12'h056);
      checkOutput("cjp_strobes", {PL_BAR, MAP_BAR, VECT_BAR}, 3'b011);
      applyStimulus(4'd14, 1'b0, 12'h000);
      RLD_BAR = 1'b0;
      stepClk();
      RLD_BAR = 1'b1;
      checkOutput("rld_rzero", RZERO, 1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/useq_stacked.md
USEQ_STACKED -- requirements
Module: useq_stacked

Interface
REQ-001 SHALL have parameter WIDTH, default 12, microaddress/data/counter width (4..64).
REQ-002 SHALL have parameter DEPTH, default 5, stack entries (2..256); SPW = clog2(DEPTH+1).
REQ-003 SHALL have ports: clk  in  1  rising-edge clock; RST_BAR  in  1  reset; reset is asynchronous and active-low.
REQ-004 SHALL have ports: I  in  4  opcode; CCEN_BAR  in  1  condition enable (low = test CC); CC_BAR  in  1  condition (low = pass); RLD_BAR  in  1  low forces R<-D; CI  in  1  uPC increment carry.
REQ-005 SHALL have ports: HOLD  in  1  stall, all state frozen; ERR_CLR  in  1  clears sticky error flags; D  in  WIDTH  direct/branch data.
REQ-006 SHALL have ports: Y  out  WIDTH  next microaddress (combinational); SP  out  SPW  stack occupancy; FULL_BAR  out  1  low when SP==DEPTH; EMPTY  out  1  SP==0; RZERO  out  1  R==0.
REQ-007 SHALL have ports: PL_BAR, MAP_BAR, VECT_BAR  out  1 each, active low for I in {all except 2,6}, {2}, {6} respectively; OVF, UNF  out  1  sticky overflow/underflow.

Function
REQ-008 fail = CC_BAR & ~CCEN_BAR; pass = ~fail; TOS = stack[SP-1], reads 0 when EMPTY.
REQ-009 Y/stack/R per opcode: 0 JZ Y=0, SP<-0; 1 CJS pass Y=D+push, fail Y=uPC; 2 JMAP Y=D; 3 CJP pass D, fail uPC.
REQ-010 4 PUSH Y=uPC, push always, pass also R<-D; 5 JSRP push always, pass Y=D, fail Y=R; 6 CJV pass D, fail uPC; 7 JRP pass D, fail R.
REQ-011 8 RFCT R!=0 Y=TOS, R-1; R==0 Y=uPC, pop; 9 RPCT R!=0 Y=D, R-1; R==0 Y=uPC.
REQ-012 10 CRTN pass Y=TOS+pop, fail uPC; 11 CJPP pass Y=D+pop, fail uPC; 12 LDCT Y=uPC, R<-D; 13 LOOP pass Y=uPC+pop, fail Y=TOS; 14 CONT Y=uPC.
REQ-013 15 TWB: R!=0 fail Y=TOS, R-1; R!=0 pass Y=uPC, pop, R-1; R==0 fail Y=D, pop; R==0 pass Y=uPC, pop.
REQ-014 Each non-HOLD edge: uPC <- (Y + CI) mod 2^WIDTH, JZ included (uPC <- CI).
REQ-015 Push writes current uPC (pre-edge value) to stack[SP], SP+1; pop SP-1; one stack op per cycle max.
REQ-016 Push when SP==DEPTH: no write, SP unchanged, OVF<-1.
REQ-017 Pop when SP==0: SP unchanged, UNF<-1; Y uses TOS=0.
REQ-018 RLD_BAR low: R <- D, overriding any decrement/load; decrement never wraps below 0 (only occurs when R!=0).
REQ-019 HOLD high: uPC, R, SP, stack, flags unchanged; Y and flag outputs still driven combinationally; OVF/UNF not set.
REQ-020 ERR_CLR high clears OVF/UNF on the edge; simultaneous new error wins (flag stays 1); ERR_CLR acts even under HOLD.
REQ-021 Overflowed push with JZ impossible (single opcode); JZ clears SP regardless of prior state and does not set flags.
REQ-022 Stack entries outside 0..SP-1 SHALL never affect Y.

Reset
REQ-023 RST_BAR low asynchronously: uPC=0, R=0, SP=0, OVF=0, UNF=0; stack contents not reset.
REQ-024 Outputs after reset: SP=0, EMPTY=1, FULL_BAR=1, RZERO=1; Y per opcode with uPC=R=0.
REQ-025 Reset asserted mid-sequence overrides HOLD and all opcodes; first post-release edge behaves as normal operation.

Verification
REQ-026 Reset, I=14, CI=1, 4 edges -> Y=0,1,2,3; uPC=4; SP=0.
REQ-027 uPC=0x010, I=1 pass, D=0x100 -> Y=0x100, SP=1; then I=10 pass -> Y=0x011, SP=0.
REQ-028 DEPTH=5, six pushes (I=4) -> SP=5, FULL_BAR=0 after fifth, OVF=1 after sixth, stack[4] unchanged; ERR_CLR -> OVF=0.
REQ-029 Empty stack, I=10 pass -> Y=0, UNF=1, SP=0.
REQ-030 I=12 D=3, then I=8 loop with pushed address A -> Y=A three times (R 3->0), fourth cycle Y=uPC, SP decremented.
REQ-031 HOLD=1 for 3 cycles during I=9 with R=2 -> R stays 2, uPC frozen; RST_BAR pulse mid-hold -> uPC=R=SP=0 immediately.
